// File: rtl/mem_word_ctrl.sv
// Word-to-byte memory access controller: turns one 16-bit word request into two
// sequential accesses on an 8-bit byte RAM (low byte first, then high byte).
// Optional feature macro: MEM_WORD_CTRL_BYTE_WRITE_EN adds a 2-bit req_be byte-enable input.
module mem_word_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
`ifdef MEM_WORD_CTRL_BYTE_WRITE_EN
  input  logic [1:0]  req_be,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [7:0]  ram_in,
  output logic        ram_load,
  output logic [14:0] ram_address,
  input  logic [7:0]  ram_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  // Byte select of the last RAM access; keeps address/data stable outside LO/HI.
  logic        hi_sel_q, hi_sel_d;
  logic        accept;
  logic        be_lo, be_hi;

`ifdef MEM_WORD_CTRL_BYTE_WRITE_EN
  logic [1:0]  be_q, be_d;
  assign be_lo = be_q[0];
  assign be_hi = be_q[1];
`else
  assign be_lo = 1'b1;
  assign be_hi = 1'b1;
`endif

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign accept    = req_valid & req_ready;

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_WORD_CTRL_BYTE_WRITE_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLo;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MEM_WORD_CTRL_BYTE_WRITE_EN
          be_d    = req_be;
`endif
        end
      end
      StLo: begin
        state_d = StHi;
        if (!we_q) rdata_d[7:0] = ram_out;
      end
      StHi: begin
        state_d = StResp;
        if (!we_q) rdata_d[15:8] = ram_out;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM port drive; writes are gated off whenever reset is high.
  always_comb begin
    hi_sel_d = hi_sel_q;
    if (state_q == StLo) hi_sel_d = 1'b0;
    if (state_q == StHi) hi_sel_d = 1'b1;
    ram_address = {addr_q, hi_sel_d};
    ram_in      = hi_sel_d ? wdata_q[15:8] : wdata_q[7:0];
    ram_load    = !reset && we_q &&
                  (((state_q == StLo) && be_lo) || ((state_q == StHi) && be_hi));
  end

  // Control state with synchronous reset; an interrupted access is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= 16'h0000;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  // Datapath registers; no reset needed since they are qualified by state.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    hi_sel_q <= hi_sel_d;
`ifdef MEM_WORD_CTRL_BYTE_WRITE_EN
    be_q     <= be_d;
`endif
  end

endmodule

// File: doc/mem_word_ctrl.md
MEM_WORD_CTRL -- requirements
Module: mem_word_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  word request present.
REQ-004 SHALL have port: req_ready  output  1  request accepted when req_valid and req_ready are both high at a clock edge.
REQ-005 SHALL have port: req_we  input  1  1 = word write, 0 = word read.
REQ-006 SHALL have port: req_addr  input  14  word address; byte addresses are {req_addr,0} (low byte) and {req_addr,1} (high byte).
REQ-007 SHALL have port: req_wdata  input  16  write data; [7:0] goes to the low byte, [15:8] to the high byte.
REQ-008 SHALL have port: rsp_valid  output  1  one-cycle completion pulse, for reads and writes alike.
REQ-009 SHALL have port: rsp_rdata  output  16  read word, valid while rsp_valid is high.
REQ-010 SHALL have ports to the 8-bit byte RAM: ram_in output 8, ram_load output 1, ram_address output 15, ram_out input 8.
  - RAM read is combinational on ram_address.
  - RAM write happens on the clock edge while ram_load is high.

Function
REQ-011 SHALL implement FSM states IDLE, LO, HI, RESP with these transitions:
  - IDLE -> LO on accept.
  - LO -> HI unconditionally.
  - HI -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
REQ-012 SHALL drive req_ready=1 only in IDLE; only one request is outstanding at a time, and no request is accepted in LO, HI or RESP.
REQ-013 SHALL latch req_we, req_addr and req_wdata on accept; later changes on the req_* inputs SHALL have no effect on the in-flight access.
REQ-014 SHALL drive the RAM in LO as follows:
  - ram_address = {addr,0}.
  - ram_in = wdata[7:0].
  - ram_load = we.
  - On a read, capture ram_out into rdata[7:0] at the end of LO.
REQ-015 SHALL drive the RAM in HI as follows:
  - ram_address = {addr,1}.
  - ram_in = wdata[15:8].
  - ram_load = we.
  - On a read, capture ram_out into rdata[15:8] at the end of HI.
REQ-016 SHALL hold ram_load=0 in IDLE and RESP; ram_address and ram_in in those states SHALL be don't-care, but held stable at the last value.
REQ-017 SHALL assert rsp_valid for exactly the RESP cycle, i.e. 3 cycles after the accept edge; back-to-back throughput is one word per 4 cycles.
REQ-018 SHALL hold rsp_rdata at its last captured value after RESP; on writes, rsp_rdata SHALL be unchanged from its previous value.
REQ-019 SHALL handle address wrap: word address 14'h3FFF maps to byte addresses 15'h7FFE and 15'h7FFF; there is no carry or overflow.
REQ-020 SHALL, when req_valid is held high during RESP, accept the next request in the following IDLE cycle; there is no accept in RESP itself.

Reset
REQ-021 SHALL, while reset is high at a clock edge, set:
  - FSM to IDLE.
  - Captured rdata to 16'h0000.
  - rsp_valid to 0.
  - Latched we to 0.
REQ-022 SHALL gate ram_load low combinationally whenever reset is high, so no RAM write occurs in a reset cycle, including reset asserted in LO or HI.
REQ-023 SHALL abandon any access interrupted by reset without a response; a write interrupted after LO leaves the low byte written and the high byte untouched.
REQ-024 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, when macro MEM_WORD_CTRL_BYTE_WRITE_EN is defined:
  - Add port req_be (input, 2 bits), latched on accept.
  - Drive ram_load in LO = we & be[0].
  - Drive ram_load in HI = we & be[1].
  - Reads ignore be.
  - Timing and rsp_valid are unchanged, including when be=2'b00.
REQ-026 SHALL, when MEM_WORD_CTRL_BYTE_WRITE_EN is undefined, have no req_be port and write both bytes on every write.

Verification
REQ-027 SHALL verify write: accept we=1, addr=14'h0012, wdata=16'hBEEF -> byte 15'h0024=8'hEF written in LO, byte 15'h0025=8'hBE written in HI, rsp_valid at accept+3.
REQ-028 SHALL verify read: after REQ-027, accept we=0, addr=14'h0012 -> rsp_valid at accept+3 with rsp_rdata=16'hBEEF, and ram_load=0 throughout.
REQ-029 SHALL verify wrap: write 16'h1234 to addr 14'h3FFF -> bytes 15'h7FFE=8'h34 and 15'h7FFF=8'h12; a readback returns 16'h1234.
REQ-030 SHALL verify reset mid-op: write 16'hA5C3 to a location holding 16'h0000, assert reset in the HI cycle -> low byte=8'hC3, high byte=8'h00, no rsp_valid, req_ready=1 the cycle after release.
REQ-031 SHALL verify back-to-back: req_valid held high with two reads -> accepts 4 cycles apart, with exactly two rsp_valid pulses.
REQ-032 SHALL verify byte enable (macro defined): write 16'hFFFF with be=2'b10 over 16'h0000 -> readback 16'hFF00.
